// File: rtl/gpc303_arbiter.sv
// gpc303_arbiter: round-robin sharing of one gpc303_4 counter among NREQ requesters.
// Define GPC303_ARBITER_CHECK_EN to build the arithmetic self-checker that drives err.

module gpc303_4 (
    input  logic [2:0] src0,
    input  logic [2:0] src2,
    output logic [3:0] dst
);
    // Each 3-bit column compresses in a full adder; the two columns never overlap in weight.
    assign dst = {src2[0] & src2[1] | src2[2] & (src2[0] ^ src2[1]), ^src2,
                  src0[0] & src0[1] | src0[2] & (src0[0] ^ src0[1]), ^src0};
endmodule

module gpc303_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_src0,
    input  logic [3*NREQ-1:0] req_src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_dst,
    output logic [IDW-1:0]    out_id,
    output logic              err
);
    localparam int PW = IDW + 1;
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nxt;
    logic [IDW-1:0] ptr, win;
    logic [PW-1:0] idx;
    logic [NREQ-1:0] sel;
    logic [2:0] op0, op2;
    logic [3:0] sum;
    logic found, slot_free, grant;
    assign out_valid = state == FULL;
    assign slot_free = !out_valid || out_ready;
    // Scan from the farthest offset down so the nearest valid requester at or after ptr wins.
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + PW'(k);
            if (idx >= PW'(NREQ)) idx = idx - PW'(NREQ);
            if (req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                win = idx[IDW-1:0];
            end
        end
    end
    assign grant = found && slot_free && !rst;
    assign sel = found ? NREQ'(1) << win : '0;
    assign req_ready = grant ? sel : '0;
    always_comb begin
        op0 = '0;
        op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            op0 = op0 | (sel[i] ? req_src0[3*i+:3] : 3'b000);
            op2 = op2 | (sel[i] ? req_src2[3*i+:3] : 3'b000);
        end
    end
    gpc303_4 u_gpc (.src0(op0), .src2(op2), .dst(sum));
    always_comb state_nxt = grant ? FULL : (out_ready ? EMPTY : state);
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            out_dst <= '0;
            out_id <= '0;
        end else if (grant) begin
            ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            out_dst <= sum;
            out_id <= win;
        end
    end
`ifdef GPC303_ARBITER_CHECK_EN
    logic [1:0] pa, pb;
    logic [3:0] sum_ref;
    assign pa = 2'(op0[0]) + 2'(op0[1]) + 2'(op0[2]);
    assign pb = 2'(op2[0]) + 2'(op2[1]) + 2'(op2[2]);
    assign sum_ref = {pb, 2'b00} + {2'b00, pa};
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (grant && sum != sum_ref) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_gpc303_arbiter.sv
// tb_gpc303_arbiter: directed vectors with hand-computed expectations for gpc303_arbiter.

module tb_gpc303_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req_valid, req_ready;
    logic [11:0] req_src0, req_src2;
    logic out_valid, out_ready, err;
    logic [3:0] out_dst;
    logic [1:0] out_id;
    int vectors = 0;
    int miscompares = 0;

    gpc303_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_src0(req_src0), .req_src2(req_src2), .out_valid(out_valid),
        .out_ready(out_ready), .out_dst(out_dst), .out_id(out_id), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        req_src0 = '0;
        req_src2 = '0;
        #1;
        chk("ready_in_rst", 32'(req_ready), 32'h0);
        tick;
        tick;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_dst", 32'(out_dst), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        // single request from requester 0, all ones -> 15
        rst = 1'b0;
        req_valid = 4'b0001;
        req_src0[2:0] = 3'b111;
        req_src2[2:0] = 3'b111;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick;
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_dst", 32'(out_dst), 32'd15);
        chk("single_id", 32'(out_id), 32'h0);
        chk("single_err", 32'(err), 32'h0);
        req_valid = 4'b0000;
        tick;
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_dst_hold", 32'(out_dst), 32'd15);
        chk("drain_id_hold", 32'(out_id), 32'h0);
        // rotation from pointer 0: 101/010 -> 2 + 4 = 6
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req_src0 = 12'b101_101_101_101;
        req_src2 = 12'b010_010_010_010;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick;
            chk("rr_valid", 32'(out_valid), 32'h1);
            chk("rr_dst", 32'(out_dst), 32'd6);
            chk("rr_id", 32'(out_id), 32'(k % 4));
        end
        // backpressure: slot holds id 0 / dst 6, pointer is 1
        req_src0[5:3] = 3'b011;
        req_src2[5:3] = 3'b000;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'h0);
            tick;
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_dst", 32'(out_dst), 32'd6);
            chk("bp_id", 32'(out_id), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0010);
        tick;
        chk("bp_nobubble_valid", 32'(out_valid), 32'h1);
        chk("bp_new_dst", 32'(out_dst), 32'd2);
        chk("bp_new_id", 32'(out_id), 32'h1);
        // pointer 2 -> grant 2 -> pointer 3, then skip with 0110
        req_valid = 4'b0100;
        tick;
        chk("to_ptr3_id", 32'(out_id), 32'h2);
        req_valid = 4'b0110;
        #1;
        chk("skip_ready", 32'(req_ready), 32'b0010);
        tick;
        chk("skip_id", 32'(out_id), 32'h1);
        #1;
        chk("skip2_ready", 32'(req_ready), 32'b0100);
        tick;
        chk("skip2_id", 32'(out_id), 32'h2);
        // pointer 3: grant 3 then wrap to 0
        req_valid = 4'b1001;
        #1;
        chk("wrap_ready3", 32'(req_ready), 32'b1000);
        tick;
        chk("wrap_id3", 32'(out_id), 32'h3);
        #1;
        chk("wrap_ready0", 32'(req_ready), 32'b0001);
        tick;
        chk("wrap_id0", 32'(out_id), 32'h0);
        // reset while full and stalled
        out_ready = 1'b0;
        req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'h0);
        tick;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_dst", 32'(out_dst), 32'h0);
        chk("midrst_id", 32'(out_id), 32'h0);
        chk("midrst_ready_after", 32'(req_ready), 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_ptr0", 32'(req_ready), 32'b0001);
        // all 64 operand combinations through requester 2
        req_valid = 4'b0100;
        for (int v = 0; v < 64; v++) begin
            req_src0[8:6] = 3'(v);
            req_src2[8:6] = 3'(v >> 3);
            tick;
            chk("sweep_dst", 32'(out_dst), 32'($countones(v & 7) + 4 * $countones(v >> 3)));
            chk("sweep_id", 32'(out_id), 32'h2);
        end
        chk("sweep_err", 32'(err), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
